// File: rtl/async_fifo_param_if.sv
// Producer/consumer signal bundle for async_fifo_param.
// The FIFO takes the slave view; the producer/consumer logic takes the master view.
interface async_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  overflow;

    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rd_count;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, almost_full, wr_count, overflow,
        input  rd_data, rd_valid, empty, almost_empty, rd_count, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, almost_full, wr_count, overflow,
        output rd_data, rd_valid, empty, almost_empty, rd_count, underflow
    );
endinterface

// File: rtl/async_fifo_param.sv
// Parametrised dual-clock FIFO with gray-pointer synchronisers, registered flags,
// almost thresholds, per-domain counts, sticky error flags and optional FWFT read.
module async_fifo_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 14,
    parameter int AE_LEVEL    = 2,
    parameter int FWFT        = 0
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst_n,
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    async_fifo_param_if.slave    bus
);
    localparam int AW    = ADDR_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [AW:0] ptr_t;

    localparam ptr_t AF_THR = ptr_t'(AF_LEVEL);
    localparam ptr_t AE_THR = ptr_t'(AE_LEVEL);

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    ptr_t wr_bin_reg, wr_gray_reg, wr_count_reg;
    ptr_t wr_bin_next, wr_gray_next, wr_count_next;
    ptr_t rq_sync_reg [SYNC_STAGES];
    ptr_t rq_gray;
    logic full_reg, full_next, almost_full_reg, overflow_reg, wr_accept;

    // read-domain gray pointer, declared here because the write side samples it
    ptr_t rd_gray_reg;

    always_comb begin
        wr_accept     = bus.wr_en && !full_reg;
        rq_gray       = rq_sync_reg[SYNC_STAGES-1];
        wr_bin_next   = wr_bin_reg + ptr_t'(wr_accept);
        wr_gray_next  = bin2gray(wr_bin_next);
        // full when the write pointer is exactly one lap ahead of the read pointer
        full_next     = (wr_gray_next == {~rq_gray[AW:AW-1], rq_gray[AW-2:0]});
        wr_count_next = wr_bin_next - gray2bin(rq_gray);
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_bin_reg      <= '0;
            wr_gray_reg     <= '0;
            wr_count_reg    <= '0;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rq_sync_reg[i] <= '0;
            end
        end else begin
            rq_sync_reg[0] <= rd_gray_reg;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rq_sync_reg[i] <= rq_sync_reg[i-1];
            end
            wr_bin_reg      <= wr_bin_next;
            wr_gray_reg     <= wr_gray_next;
            wr_count_reg    <= wr_count_next;
            full_reg        <= full_next;
            almost_full_reg <= (wr_count_next >= AF_THR);
            if (bus.wr_en && full_reg) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // storage has no reset so it can map onto block RAM
    always_ff @(posedge wr_clk) begin
        if (wr_accept) begin
            mem[wr_bin_reg[AW-1:0]] <= bus.wr_data;
        end
    end

    assign bus.full        = full_reg;
    assign bus.almost_full = almost_full_reg;
    assign bus.wr_count    = wr_count_reg;
    assign bus.overflow    = overflow_reg;

    // ---------------- read domain ----------------
    ptr_t rd_bin_reg, rd_count_reg;
    ptr_t rd_bin_next, rd_gray_next, rd_count_next;
    ptr_t wq_sync_reg [SYNC_STAGES];
    ptr_t wq_gray;
    logic mem_empty_reg, mem_empty_next, almost_empty_reg, underflow_reg;
    logic mem_pop, rd_fault;
    logic rd_valid_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;

    always_comb begin
        wq_gray        = wq_sync_reg[SYNC_STAGES-1];
        rd_bin_next    = rd_bin_reg + ptr_t'(mem_pop);
        rd_gray_next   = bin2gray(rd_bin_next);
        mem_empty_next = (rd_gray_next == wq_gray);
        rd_count_next  = gray2bin(wq_gray) - rd_bin_next;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_bin_reg       <= '0;
            rd_gray_reg      <= '0;
            rd_count_reg     <= '0;
            mem_empty_reg    <= 1'b1;
            almost_empty_reg <= 1'b1;
            underflow_reg    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wq_sync_reg[i] <= '0;
            end
        end else begin
            wq_sync_reg[0] <= wr_gray_reg;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wq_sync_reg[i] <= wq_sync_reg[i-1];
            end
            rd_bin_reg       <= rd_bin_next;
            rd_gray_reg      <= rd_gray_next;
            rd_count_reg     <= rd_count_next;
            mem_empty_reg    <= mem_empty_next;
            almost_empty_reg <= (rd_count_next <= AE_THR);
            if (rd_fault) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // output register refills from memory whenever it is vacant or being popped
            assign mem_pop  = !mem_empty_reg && (!rd_valid_reg || bus.rd_en);
            assign rd_fault = bus.rd_en && !rd_valid_reg;

            always_ff @(posedge rd_clk or negedge rd_rst_n) begin
                if (!rd_rst_n) begin
                    rd_valid_reg <= 1'b0;
                    rd_data_reg  <= '0;
                end else if (mem_pop) begin
                    rd_valid_reg <= 1'b1;
                    rd_data_reg  <= mem[rd_bin_reg[AW-1:0]];
                end else if (bus.rd_en) begin
                    rd_valid_reg <= 1'b0;
                end
            end

            assign bus.empty = !rd_valid_reg;
        end else begin : g_std
            assign mem_pop  = bus.rd_en && !mem_empty_reg;
            assign rd_fault = bus.rd_en && mem_empty_reg;

            always_ff @(posedge rd_clk or negedge rd_rst_n) begin
                if (!rd_rst_n) begin
                    rd_valid_reg <= 1'b0;
                    rd_data_reg  <= '0;
                end else begin
                    rd_valid_reg <= mem_pop;
                    if (mem_pop) begin
                        rd_data_reg <= mem[rd_bin_reg[AW-1:0]];
                    end
                end
            end

            assign bus.empty = mem_empty_reg;
        end
    endgenerate

    assign bus.rd_data      = rd_data_reg;
    assign bus.rd_valid     = rd_valid_reg;
    assign bus.almost_empty = almost_empty_reg;
    assign bus.rd_count     = rd_count_reg;
    assign bus.underflow    = underflow_reg;
endmodule

// File: doc/async_fifo_param.md
Name: async_fifo_param

Overview:
Parametrised dual-clock FIFO; successor to the fixed 8x8 async FIFO. It generalises width and depth and adds a configurable synchroniser depth and registered full/empty flags. It also adds almost-full/almost-empty thresholds, per-domain fill counts, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode. It sits between producer and consumer clock domains in the datapath.

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (>=2)
SYNC_STAGES, 2, flops in each gray-pointer synchroniser (>=2)
AF_LEVEL, 14, almost_full asserts when wr_count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when rd_count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
wr_clk  in  1  write clock
wr_rst_n  in  1  write-domain reset
rd_clk  in  1  read clock
rd_rst_n  in  1  read-domain reset, asynchronous, active-low
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
full  out  1  no space; registered in wr_clk
almost_full  out  1  wr_count >= AF_LEVEL
wr_count  out  ADDR_WIDTH+1  occupancy seen from write side (0..DEPTH)
overflow  out  1  sticky: write attempted while full
rd_en  in  1  read request / pop
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data holds a valid word
empty  out  1  no data; registered in rd_clk
almost_empty  out  1  rd_count <= AE_LEVEL
rd_count  out  ADDR_WIDTH+1  occupancy seen from read side
underflow  out  1  sticky: read attempted while empty
Interface: reset wr_rst_n, asynchronous, active-low; clock wr_clk. The read domain uses rd_clk and rd_rst_n (asynchronous, active-low).

Behaviour:
- Pointers: binary plus gray, ADDR_WIDTH+1 bits each; gray = bin ^ (bin>>1); only registered gray crosses domains, through SYNC_STAGES flops reset to 0.
- Write accept = wr_en && !full: mem[wr_bin[ADDR_WIDTH-1:0]] <= wr_data, wr_bin++. Memory is not reset.
- full is registered from the next write gray pointer: full_next = (wr_gray_next == {~rq_gray[MSB:MSB-1], rq_gray[MSB-2:0]}). It asserts on the same edge that accepts the DEPTH-th word.
- empty is registered: empty_next = (rd_gray_next == wq_gray). It asserts on the edge that pops the last word.
- Counts: wr_count = wr_bin - gray2bin(rq_gray); rd_count = gray2bin(wq_gray) - rd_bin. Both are modulo 2**(ADDR_WIDTH+1) and registered. They are pessimistic: wr_count over-reports and rd_count under-reports by synchroniser lag.
- almost_full and almost_empty are registered from the next-state counts, so they update on the same edge as the counts.
- Write-to-read latency: empty deasserts no later than SYNC_STAGES+1 rd_clk edges after the accepting wr_clk edge. Read-to-write: full deasserts no later than SYNC_STAGES+1 wr_clk edges after the pop.
- FWFT=0: accept = rd_en && !empty. rd_data <= head at that edge, and rd_valid is a 1-cycle pulse in the following cycle. rd_data holds otherwise.
- FWFT=1: an output register is prefetched from memory whenever it is empty and the memory holds data. rd_valid=1 while it holds a word, and rd_data = head. rd_en && rd_valid pops the word. empty = !rd_valid.
- Overflow: wr_en && full drops the data, leaves the pointer unchanged and sets overflow on the next edge. Overflow clears only on wr_rst_n.
- Underflow: rd_en && empty (or !rd_valid in FWFT) leaves the pointer unchanged and sets underflow. Underflow clears only on rd_rst_n.
- Simultaneous write and read in the same real time are independent. At a wrap-around the MSB toggle distinguishes full from empty.
- Reset values: full=0, almost_full=0, wr_count=0, overflow=0, rd_data=0, rd_valid=0, empty=1, almost_empty=1, rd_count=0, underflow=0.
- Reset mid-operation: each reset clears only its own domain. Both resets must be asserted together for at least 2 cycles of the slower clock. With only one reset asserted, flags are undefined until both are deasserted.

Test Plan:
- Reset both domains with wr_clk=100MHz and rd_clk=37MHz -> empty=1, full=0, rd_valid=0, counts=0, almost_empty=1.
- Write 16 words 0x00..0x0F with no reads -> full=1 on the 16th accept edge; almost_full=1 from wr_count=14; a 17th write of 0xAA sets overflow=1; 16 reads then return exactly 0x00..0x0F.
- Drain the FIFO, then issue one extra rd_en -> empty=1 and underflow=1; rd_data holds 0x0F; the pointer is unchanged, and a following write/read of 0x55 returns 0x55.
- Run 1000 random words with random wr_en/rd_en under both clock ratios (fast-write and fast-read) -> scoreboard order matches, with no loss and no duplication across at least 3 pointer wraps.
- FWFT=1: write 0x3C into an empty FIFO -> rd_valid=1 with rd_data=0x3C within SYNC_STAGES+2 rd_clk edges, before any rd_en; rd_en then pops it and empty=1.
- Assert both resets while the FIFO holds 5 words -> all outputs return to their reset values and a new write of 0x77 reads back as 0x77.
